// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame assembler: collects WIDTH qualified serial bits
// (LSB first) after a start strobe and hands the word over a valid/ready holding register.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned SREG_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [SREG_W-1:0]  sreg;
  logic [SREG_W-1:0]  sreg_n;
  logic [WIDTH-1:0]   dout_n;
  logic               dout_valid_n;
  logic               overrun_n;
  logic               busy_n;
  logic               done_c;
  logic [WIDTH-1:0]   word_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, datapath and output-register next values
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sreg_n       = sreg;
    done_c       = 1'b0;
    dout_n       = dout;
    dout_valid_n = dout_valid;
    overrun_n    = overrun;
    // Only the first WIDTH-1 bits need storage; the last bit goes straight into the word.
    word_c       = {sin, sreg};

    case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          cnt_n   = '0;
          sreg_n  = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_n  = '0;
          sreg_n = '0;
        end else if (sin_en) begin
          sreg_n = word_c[WIDTH-1:1];
          if (cnt == LAST_BIT) begin
            done_c  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A completed word either takes the holding register or is dropped as an overrun.
    if (done_c) begin
      if (!dout_valid || dout_ready) begin
        dout_n       = word_c;
        dout_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid_n = 1'b0;
    end

    busy_n = (state_n == SHIFT);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sreg       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      sreg       <= sreg_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      overrun    <= overrun_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed frame scenarios plus a randomized run,
// all checked against a queue-based frame model.
module tb_sipo_frame_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sin;
  logic             sin_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic             m_busy  = 1'b0;
  logic             m_valid = 1'b0;
  logic             m_ovr   = 1'b0;
  logic [WIDTH-1:0] m_dout  = '0;
  bit               q[$];

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sin        (sin),
    .sin_en     (sin_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Frame-level model: bits collect in a queue, a full queue becomes a word.
  task automatic model_edge(input logic st, input logic b, input logic en,
                            input logic rdy, input logic r);
    logic             done;
    logic [WIDTH-1:0] word;
    done = 1'b0;
    word = '0;
    if (r) begin
      m_busy = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_dout = '0;
      q.delete();
      return;
    end
    if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1;
        q.delete();
      end
    end else if (st) begin
      q.delete();
    end else if (en) begin
      q.push_back(b);
      if (q.size() == WIDTH) begin
        foreach (q[i]) word[i] = q[i];
        done   = 1'b1;
        m_busy = 1'b0;
        q.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_dout  = word;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic st, input logic b, input logic en,
                      input logic rdy, input logic r);
    start = st; sin = b; sin_en = en; dout_ready = rdy; rst = r;
    @(posedge clk);
    model_edge(st, b, en, rdy, r);
    #1;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits, input logic rdy);
    for (int i = 0; i < nbits; i++) step(1'b0, w[i], 1'b1, rdy, 1'b0);
  endtask

  task automatic test_reset();
    step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({busy, dout_valid, overrun, dout} !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b ovr=%b dout=%h, want all 0", busy, dout_valid, overrun, dout);
    end
  endtask

  task automatic test_basic_a5();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL a5_start: busy=%b valid=%b, want 1 0", busy, dout_valid);
    end
    send_bits(8'hA5, 8, 1'b1);
    checks++;
    if ({busy, dout_valid, overrun, dout} !== {3'b010, 8'hA5}) begin
      errors++;
      $display("FAIL a5_done: busy=%b valid=%b ovr=%b dout=%h, want 0 1 0 a5", busy, dout_valid, overrun, dout);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'hA5) begin
      errors++;
      $display("FAIL a5_consumed: valid=%b dout=%h, want 0 a5", dout_valid, dout);
    end
  endtask

  task automatic test_gaps();
    int bad;
    logic [WIDTH-1:0] w;
    bad = 0;
    w = 8'hA5;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'($urandom), 1'b0, 1'b1, 1'b0);
          if (busy !== 1'b1 || dout_valid !== 1'b0) bad++;
        end
      end
      step(1'b0, w[i], 1'b1, 1'b1, 1'b0);
      if (i < WIDTH - 1 && busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gaps_busy: %0d cycles with busy low or early valid, want 0", bad);
    end
    checks++;
    if ({busy, dout_valid, dout} !== {2'b01, 8'hA5}) begin
      errors++;
      $display("FAIL gaps_done: busy=%b valid=%b dout=%h, want 0 1 a5", busy, dout_valid, dout);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h3C, 8, 1'b0);
    checks++;
    if ({dout_valid, overrun, dout} !== {2'b10, 8'h3C}) begin
      errors++;
      $display("FAIL ovr_first: valid=%b ovr=%b dout=%h, want 1 0 3c", dout_valid, overrun, dout);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'hFF, 8, 1'b0);
    checks++;
    if ({busy, dout_valid, overrun, dout} !== {3'b011, 8'h3C}) begin
      errors++;
      $display("FAIL ovr_drop: busy=%b valid=%b ovr=%b dout=%h, want 0 1 1 3c", busy, dout_valid, overrun, dout);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({dout_valid, overrun, dout} !== {2'b01, 8'h3C}) begin
      errors++;
      $display("FAIL ovr_sticky: valid=%b ovr=%b dout=%h, want 0 1 3c", dout_valid, overrun, dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w;
    w = 8'h22;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h11, 8, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(w, 7, 1'b0);
    checks++;
    if ({busy, dout_valid, dout} !== {2'b11, 8'h11}) begin
      errors++;
      $display("FAIL b2b_hold: busy=%b valid=%b dout=%h, want 1 1 11", busy, dout_valid, dout);
    end
    step(1'b0, w[7], 1'b1, 1'b1, 1'b0);
    checks++;
    if ({busy, dout_valid, overrun, dout} !== {3'b010, 8'h22}) begin
      errors++;
      $display("FAIL b2b_replace: busy=%b valid=%b ovr=%b dout=%h, want 0 1 0 22", busy, dout_valid, overrun, dout);
    end
  endtask

  task automatic test_restart();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(8'h0F, 4, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_busy: busy=%b, want 1", busy);
    end
    send_bits(8'h5A, 8, 1'b1);
    checks++;
    if ({busy, dout_valid, dout} !== {2'b01, 8'h5A}) begin
      errors++;
      $display("FAIL restart_word: busy=%b valid=%b dout=%h, want 0 1 5a", busy, dout_valid, dout);
    end
  endtask

  task automatic test_reset_midframe();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'h1F, 5, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({busy, dout_valid, overrun, dout} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: busy=%b valid=%b ovr=%b dout=%h, want all 0", busy, dout_valid, overrun, dout);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(8'hC3, 8, 1'b0);
    checks++;
    if ({busy, dout_valid, overrun, dout} !== {3'b010, 8'hC3}) begin
      errors++;
      $display("FAIL midrst_word: busy=%b valid=%b ovr=%b dout=%h, want 0 1 0 c3", busy, dout_valid, overrun, dout);
    end
  endtask

  task automatic test_random();
    logic r, st, en, rdy;
    for (int n = 0; n < 4000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 29) == 0);
      en  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      step(st, 1'($urandom), en, rdy, r);
      checks++;
      if ({busy, dout_valid, overrun, dout} !== {m_busy, m_valid, m_ovr, m_dout}) begin
        errors++;
        $display("FAIL random cycle %0d: busy=%b valid=%b ovr=%b dout=%h, want %b %b %b %h",
                 n, busy, dout_valid, overrun, dout, m_busy, m_valid, m_ovr, m_dout);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sin = 1'b0; sin_en = 1'b0; dout_ready = 1'b0;
    test_reset();
    test_basic_a5();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_restart();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
